// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and block geometry for the block transmitter/receiver pair.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int BYTES_PER_BLOCK = 16;
    localparam int BITS_PER_BYTE   = 8;
    localparam int BLOCK_W         = BYTES_PER_BLOCK * BITS_PER_BYTE;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_NEXT   = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick_o marks the last cycle of each BAUD_CNT-cycle bit.
// clr_i restarts the period so every FSM state starts on a fresh bit boundary.
module uart_baud_gen #(
    parameter int BAUD_CNT = 434
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr_i,
    output logic bit_tick_o
);

    localparam int CNT_W = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || bit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_block_tx.sv
// 128-bit block UART transmitter: sends 16 bytes MSB-byte first, each 8N1 (8E1 with UART_TX_PARITY_EN).
// A rising edge of send_en in IDLE captures send_data; edges while busy are dropped.
module uart_block_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               send_en,
    input  logic [BLOCK_W-1:0] send_data,
    output logic               tx_busy,
    output logic               uart_txd
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_BLOCK - 1);
    localparam logic [2:0] LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    logic               en_d0_q, en_d1_q;
    logic               start_flag;
    tx_state_e          state_q, state_d;
    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [3:0]         byte_idx_q, byte_idx_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic               busy_q, busy_d;
    logic               txd_q, txd_d;
    logic [7:0]         cur_byte;
    logic               bit_tick;
    logic               baud_clr;

    assign start_flag = en_d0_q & ~en_d1_q;
    assign baud_clr   = (state_d != state_q);

    uart_baud_gen #(
        .BAUD_CNT (BAUD_CNT)
    ) u_baud_gen (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clr_i      (baud_clr),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start_flag) begin
                    buf_d      = send_data;
                    busy_d     = 1'b1;
                    byte_idx_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                // The current byte always sits in the top 8 bits; shift up to expose the next one.
                if (byte_idx_q != LAST_BYTE) begin
                    byte_idx_d = byte_idx_q + 4'd1;
                    buf_d      = {buf_q[BLOCK_W-9:0], 8'h00};
                    state_d    = ST_START;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so the registered output tracks the FSM without lag.
    always_comb begin
        cur_byte = buf_d[BLOCK_W-1 -: 8];
        txd_d    = 1'b1;
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = cur_byte[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = ^cur_byte;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            en_d0_q    <= 1'b0;
            en_d1_q    <= 1'b0;
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            byte_idx_q <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            en_d0_q    <= send_en;
            en_d1_q    <= en_d0_q;
            state_q    <= state_d;
            buf_q      <= buf_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            busy_q     <= busy_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_busy  = busy_q;
    assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_block_tx.sv
// Directed bench for uart_block_tx at CLK_FREQ=1000, BAUD_RATE=100 (10 cycles per bit).
// Honours UART_TX_PARITY_EN for frame length and parity expectations.
module tb_uart_block_tx;

    localparam int B = 10;
`ifdef UART_TX_PARITY_EN
    localparam int BYTE_LEN = 11 * B + 1;
`else
    localparam int BYTE_LEN = 10 * B + 1;
`endif
    localparam int FRAME_LEN = 16 * BYTE_LEN;
    localparam logic [127:0] PAT     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] PAR_PAT = 128'h0703A55A_FF00137F_80010203_04050607;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         send_en;
    logic [127:0] send_data;
    logic         tx_busy;
    logic         uart_txd;

    int checks = 0;
    int errors = 0;

    uart_block_tx #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .send_en   (send_en),
        .send_data (send_data),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected line level n cycles after tx_busy rises, for a block d.
    function automatic logic exp_line(input logic [127:0] d, input int n);
        int bi;
        int p;
        logic [7:0] b;
        bi = n / BYTE_LEN;
        p  = n % BYTE_LEN;
        b  = d[127 - 8 * bi -: 8];
        if (p < B) return 1'b0;
        if (p < 9 * B) return b[(p - B) / B];
`ifdef UART_TX_PARITY_EN
        if (p < 10 * B) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_busy(input logic level, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge sys_clk);
            if (tx_busy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Starts a block and checks every line cycle; optional retrigger pulse and data change.
    task automatic run_frame(input logic [127:0] d, input int retrig_at, input int chg_at, input string name);
        int busy_cycles;
        int byte_err;
        int n;
        bit ok;
        logic [7:0] eb;
        busy_cycles = 0;
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        send_data = d;
        send_en   = 1'b1;
        wait_busy(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_start: tx_busy=%b required 1 within 10 cycles", name, tx_busy);
            send_en = 1'b0;
            return;
        end
        for (int bi = 0; bi < 16; bi++) begin
            byte_err = 0;
            for (int p = 0; p < BYTE_LEN; p++) begin
                n = bi * BYTE_LEN + p;
                if (n > 0) @(negedge sys_clk);
                if (tx_busy === 1'b1) busy_cycles++;
                if (uart_txd !== exp_line(d, n)) byte_err++;
                if (n == retrig_at) send_en = 1'b0;
                if (n == retrig_at + 3) send_en = 1'b1;
                if (n == chg_at) send_data = '1;
            end
            eb = d[127 - 8 * bi -: 8];
            checks++;
            if (byte_err != 0) begin
                errors++;
                $display("FAIL %s_byte%0d: %0d wrong line cycles, required byte %h", name, bi, byte_err, eb);
            end
        end
        @(negedge sys_clk);
        checks++;
        if (tx_busy !== 1'b0 || uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: tx_busy=%b uart_txd=%b required 0/1", name, tx_busy, uart_txd);
        end
        checks++;
        if (busy_cycles != FRAME_LEN) begin
            errors++;
            $display("FAIL %s_busy_len: got %0d cycles required %0d", name, busy_cycles, FRAME_LEN);
        end
        $display("frame %s: busy %0d cycles", name, busy_cycles);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        send_en   = 1'b0;
        send_data = '0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_in: uart_txd=%b tx_busy=%b required 1/0", uart_txd, tx_busy);
        end
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: uart_txd=%b tx_busy=%b required 1/0", uart_txd, tx_busy);
        end
        $display("reset: uart_txd=%b tx_busy=%b", uart_txd, tx_busy);
    endtask

    task automatic test_frame();
        run_frame(PAT, -100, -100, "basic");
    endtask

    task automatic test_ignore_retrigger();
        int bad;
        bad = 0;
        run_frame(PAT, 500, -100, "retrig");
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL retrig_idle: %0d non-idle cycles required 0", bad);
        end
        send_en = 1'b0;
        $display("retrigger: idle-after bad cycles %0d", bad);
    endtask

    task automatic test_held_high();
        int rises;
        logic prev;
        rises = 0;
        prev  = tx_busy;
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        send_data = PAT;
        send_en   = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if (tx_busy === 1'b1 && prev !== 1'b1) rises++;
            prev = tx_busy;
        end
        send_en = 1'b0;
        checks++;
        if (rises != 1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL held_high: %0d blocks started, tx_busy=%b, required 1 block and 0", rises, tx_busy);
        end
        $display("held_high: %0d blocks started", rises);
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        send_data = PAT;
        send_en   = 1'b1;
        wait_busy(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_start: tx_busy=%b required 1", tx_busy);
        end
        repeat (5 * BYTE_LEN + 3 * B + 2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: uart_txd=%b tx_busy=%b required 1/0", uart_txd, tx_busy);
        end
        send_en = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: uart_txd=%b tx_busy=%b required 1/0", uart_txd, tx_busy);
        end
        $display("reset_mid: aborted, line idle");
        run_frame(PAT, -100, -100, "restart");
    endtask

    task automatic test_start_through_reset();
        bit ok;
        send_data = PAT;
        send_en   = 1'b1;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_busy(1'b1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_held_start: tx_busy=%b required 1", tx_busy);
        end
        wait_busy(1'b0, FRAME_LEN + 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_held_end: tx_busy=%b required 0", tx_busy);
        end
        send_en = 1'b0;
        $display("start_through_reset: block sent");
    endtask

    task automatic test_data_change();
        run_frame(PAT, -100, 0, "datachg");
    endtask

    task automatic test_parity();
        bit ok;
        run_frame(PAR_PAT, -100, -100, "parity");
`ifdef UART_TX_PARITY_EN
        send_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        send_data = PAR_PAT;
        send_en   = 1'b1;
        wait_busy(1'b1, 10, ok);
        repeat (9 * B + B / 2) @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b1) begin
            errors++;
            $display("FAIL parity_07: got %b required 1", uart_txd);
        end
        repeat (BYTE_LEN) @(negedge sys_clk);
        checks++;
        if (uart_txd !== 1'b0) begin
            errors++;
            $display("FAIL parity_03: got %b required 0", uart_txd);
        end
        wait_busy(1'b0, FRAME_LEN + 20, ok);
        send_en = 1'b0;
        $display("parity: explicit bits checked");
`else
        ok = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ignore_retrigger();
        test_held_high();
        test_reset_mid();
        test_start_through_reset();
        test_data_change();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
